bdm_boot_seq: RTL

//   Sequences the BDM ROM-copy engine: splits the boot image into bursts, issues one copy command per burst,

---
 rtl/bdm_boot_seq_pkg.sv | 16 +
 rtl/bdm_boot_seq_if.sv | 12 +
 rtl/bdm_boot_seq_burst_planner.sv | 21 ++
 rtl/bdm_boot_seq.sv | 107 ++++++++++
 4 files changed

// File: rtl/bdm_boot_seq_pkg.sv
// bdm_boot_seq_pkg: FSM state encoding, beat size and AXI LEN/RESP constants shared with the copy port
package bdm_boot_seq_pkg;
  localparam int BEAT_BYTES = 4;
  localparam int AXI_LEN_W = 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t ISSUE = 3'd1;
  localparam state_t WAIT = 3'd2;
  localparam state_t NEXT = 3'd3;
  localparam state_t DONE = 3'd4;
  localparam state_t FAIL = 3'd5;
endpackage

// File: rtl/bdm_boot_seq_if.sv
// bdm_boot_seq_if: copy command port (master=sequencer: valid/src/dst/len out, ready/done/err in; slave=engine)
interface bdm_boot_seq_if #(parameter int AW = 32);
  logic cmd_valid;
  logic cmd_ready;
  logic [AW-1:0] cmd_src_addr;
  logic [AW-1:0] cmd_dst_addr;
  logic [7:0] cmd_len;
  logic cmd_done;
  logic cmd_err;
  modport master(output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, input cmd_ready, cmd_done, cmd_err);
  modport slave(input cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_len, output cmd_ready, cmd_done, cmd_err);
endinterface

// File: rtl/bdm_boot_seq_burst_planner.sv
// bdm_boot_seq_burst_planner: registers beats=min(rem,C_BURST_LEN) on load; len is beats-1 (ports: clk, rst_n, load, rem -> beats, len)
module bdm_boot_seq_burst_planner
  import bdm_boot_seq_pkg::*;
#(
  parameter int C_BURST_LEN = 16
) (
  input  logic                 boot_aclk,
  input  logic                 boot_aresetn,
  input  logic                 load,
  input  logic [30:0]          rem,
  output logic [8:0]           beats,
  output logic [AXI_LEN_W-1:0] len
);
  logic [8:0] beats_d, beats_q;
  always_comb beats_d = !load ? beats_q : rem < 31'(C_BURST_LEN) ? 9'(rem) : 9'(C_BURST_LEN);
  always_ff @(posedge boot_aclk or negedge boot_aresetn)
    if (!boot_aresetn) beats_q <= '0;
    else beats_q <= beats_d;
  assign beats = beats_q;
  assign len = AXI_LEN_W'(beats_q - 9'd1);
endmodule

// File: rtl/bdm_boot_seq.sv
// bdm_boot_seq: boot ROM-copy sequencer (ports: clk, rst_n, start, cmd master port, boot_code_ready, core_rst_n, busy, error, bytes_copied)
module bdm_boot_seq
  import bdm_boot_seq_pkg::*;
#(
  parameter int                      C_ADDR_WIDTH     = 32,
  parameter logic [C_ADDR_WIDTH-1:0] C_BOOT_CODE_ADDR = 32'hB000_0000,
  parameter logic [C_ADDR_WIDTH-1:0] C_ROM_BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0]             C_ROM_SIZE_BYTES = 32'd65536,
  parameter int                      C_BURST_LEN      = 16,
  parameter int                      C_MAX_RETRY      = 3,
  parameter int                      C_AUTO_START     = 1
) (
  input  logic                 boot_aclk,
  input  logic                 boot_aresetn,
  input  logic                 start,
  bdm_boot_seq_if.master       cmd,
  output logic                 boot_code_ready,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic                 error,
  output logic [31:0]          bytes_copied
);
  localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * BEAT_BYTES);
  if ((C_ROM_SIZE_BYTES % 32'd4) != 32'd0 || (C_BOOT_CODE_ADDR % BURST_BYTES) != '0 ||
      (C_ROM_BASE_ADDR % BURST_BYTES) != '0 || C_BURST_LEN < 1 || C_BURST_LEN > 256) begin : g_cfg_err
    $error("bdm_boot_seq: misaligned base/size or bad burst length");
  end
  state_t state_d, state_q;
  logic [30:0] rem_d, rem_q;
  logic [C_ADDR_WIDTH-1:0] src_d, src_q, dst_d, dst_q;
  logic [3:0] retry_d, retry_q;
  logic [31:0] bytes_d, bytes_q;
  logic auto_d, auto_q, core_d, core_q;
  logic [8:0] beats;
  logic [AXI_LEN_W-1:0] len;
  bdm_boot_seq_burst_planner #(.C_BURST_LEN(C_BURST_LEN)) u_planner (
    .boot_aclk   (boot_aclk),
    .boot_aresetn(boot_aresetn),
    .load        (state_q == IDLE || state_q == NEXT),
    .rem         (rem_d),
    .beats       (beats),
    .len         (len)
  );
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    src_d = src_q;
    dst_d = dst_q;
    retry_d = retry_q;
    bytes_d = bytes_q;
    auto_d = 1'b0;
    core_d = state_q == DONE;
    case (state_q)
      IDLE: if (start || auto_q) begin
        rem_d = {1'b0, C_ROM_SIZE_BYTES[31:2]};
        src_d = C_ROM_BASE_ADDR;
        dst_d = C_BOOT_CODE_ADDR;
        state_d = C_ROM_SIZE_BYTES == 32'd0 ? DONE : ISSUE;
      end
      ISSUE: state_d = cmd.cmd_ready ? WAIT : ISSUE;
      WAIT: if (cmd.cmd_done) begin
        if (!cmd.cmd_err) begin
          rem_d = rem_q - 31'(beats);
          src_d = src_q + C_ADDR_WIDTH'({beats, 2'b00});
          dst_d = dst_q + C_ADDR_WIDTH'({beats, 2'b00});
          bytes_d = bytes_q + 32'({beats, 2'b00});
          retry_d = '0;
          state_d = NEXT;
        end else begin
          retry_d = retry_q < 4'(C_MAX_RETRY) ? retry_q + 4'd1 : retry_q;
          state_d = retry_q < 4'(C_MAX_RETRY) ? ISSUE : FAIL;
        end
      end
      NEXT: state_d = rem_q == '0 ? DONE : ISSUE;
      default: ;
    endcase
  end
  always_ff @(posedge boot_aclk or negedge boot_aresetn)
    if (!boot_aresetn) begin
      state_q <= IDLE;
      rem_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      retry_q <= '0;
      bytes_q <= '0;
      auto_q <= C_AUTO_START != 0;
      core_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      src_q <= src_d;
      dst_q <= dst_d;
      retry_q <= retry_d;
      bytes_q <= bytes_d;
      auto_q <= auto_d;
      core_q <= core_d;
    end
  assign cmd.cmd_valid = state_q == ISSUE;
  assign cmd.cmd_src_addr = state_q == ISSUE ? src_q : '0;
  assign cmd.cmd_dst_addr = state_q == ISSUE ? dst_q : '0;
  assign cmd.cmd_len = state_q == ISSUE ? len : '0;
  assign boot_code_ready = state_q == DONE;
  assign core_rst_n = core_q;
  assign busy = state_q == ISSUE || state_q == WAIT || state_q == NEXT;
  assign error = state_q == FAIL;
  assign bytes_copied = bytes_q;
endmodule
